eth_rx_framer: RTL
==================

# eth_rx_framer

Receive-side framing stage between the PHY-facing byte interface (GMII-style, one byte per `clk`) and the rx byte consumer. It strips the preamble and SFD and checks the frame. Checks cover CRC-32 over the whole frame including the FCS, frame length against `rx_tx_pkg` limits, and PHY error. The FCS is removed by a 5-byte delay line, and downstream receives payload bytes (dest addr through data) with SOF/EOF markers and per-frame status on the EOF beat. There is no backpressure; the PHY cannot stall.

## Interface
- `MIN_PREAMBLE`, default 1: minimum count of 0x55 bytes required before SFD (0xD5).
- `MIN_LEN`, default `rx_tx_pkg::MIN_FRAME_SIZE` (64): minimum frame bytes after SFD, FCS included.
- `MAX_LEN`, default `rx_tx_pkg::MAX_FRAME_SIZE` (1518): maximum frame bytes after SFD, FCS included.
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_data`  in  8  PHY byte.
- `rx_dv`  in  1  PHY data valid.
- `rx_er`  in  1  PHY error; sampled only while `rx_dv`=1.
- `m_data`  out  8  payload byte.
- `m_valid`  out  1  `m_data` valid this cycle.
- `m_sof`  out  1  first payload byte (with `m_valid`).
- `m_eof`  out  1  last payload byte (with `m_valid`); the status bits below are valid only here.
- `m_crc_err`  out  1  CRC residue mismatch.
- `m_len_err`  out  1  length outside [`MIN_LEN`, `MAX_LEN`].
- `m_phy_err`  out  1  `rx_er` seen during the frame.
- `m_good`  out  1  EOF with no error.
- `m_runt_drop`  out  1  one-cycle pulse: frame ended with ≤4 bytes after SFD, nothing emitted.

## Operation
- **States:**
  - **IDLE:**
    - `rx_dv`=1 and 0x55 → PREAMBLE, pcnt=1.
    - `rx_dv`=1 and any other byte → DROP.
  - **PREAMBLE:**
    - 0x55 → pcnt++, saturating at 7.
    - 0xD5 with pcnt≥`MIN_PREAMBLE` → DATA, clearing bcnt, CRC, delay line and error flags.
    - 0xD5 with pcnt<`MIN_PREAMBLE`, or any other byte → DROP.
    - `rx_dv`=0 → IDLE.
  - **DATA:** each byte with `rx_dv`=1:
    - bcnt++ (12-bit, saturating at 4095).
    - CRC update.
    - Shift into the 5-entry delay line.
    - If the line already held 5 bytes, emit the oldest.
    - `rx_er`=1 sets the sticky phy_err.
  - **DATA end:** the first cycle with `rx_dv`=0 ends the frame; next state IDLE.
    - If bcnt≥5, emit the oldest held byte (last payload byte) with `m_eof`=1 and status.
    - Else pulse `m_runt_drop`.
  - **DROP:** ignore input until `rx_dv`=0 → IDLE. No output.
- **CRC:**
  - Reflected CRC-32, LSB-first, poly 0xEDB88320, right-shift, init 0xFFFFFFFF, no per-byte inversion.
  - After the last FCS byte, a correct frame leaves the register at 0xDEBB20E3; any other value sets `m_crc_err`.
- **Length:** `m_len_err` = (bcnt<`MIN_LEN`) | (bcnt>`MAX_LEN`). Oversize frames are still streamed fully.
- `m_good` = `m_eof` & ~(`m_crc_err` | `m_len_err` | `m_phy_err`).
- `m_sof` is on the first emitted byte of each frame. For a 5-byte frame, `m_sof` and `m_eof` share one beat.

## Timing
- All outputs are registered. Reset value of every output is 0.
- **Reset:** state IDLE, counters, CRC and delay line cleared.
  - Reset mid-frame aborts silently: no EOF is emitted.
  - The next frame is handled normally.
- **Data latency:** payload byte i (0-based after SFD) is sampled at cycle t. It appears on `m_data` with `m_valid` at cycle t+6 (the cycle after byte i+5 is sampled).
- **EOF latency:** `rx_dv` sampled 0 at cycle T in DATA gives `m_eof`/status at T+1. CRC status includes the byte sampled at T−1.
- **Back-to-back frames:** a single `rx_dv`=0 cycle between frames is sufficient. The EOF cycle and the next frame's IDLE sampling do not conflict.
- `m_valid` is never asserted for preamble, SFD, FCS, or dropped bytes.
- A gap (`rx_dv`=0) inside DATA is treated as frame end. There is no resume.

## Test plan
- **Good 64-byte frame** (60 payload + valid FCS, 7×0x55 + 0xD5) → 60 `m_valid` beats, `m_sof` on beat 1, `m_eof` on beat 60, `m_good`=1, bytes identical to the sent payload.
- **Same frame with payload byte 10 XOR 0x01** → 60 beats, `m_crc_err`=1, `m_good`=0.
- **Length limits, valid CRC:**
  - 63-byte frame and 1519-byte frame → `m_len_err`=1.
  - 1518-byte frame → `m_good`=1, 1514 beats.
- **Bad preamble** 0x55,0x55,0x12,… then a good frame after `rx_dv` low → first burst produces no output; second gives `m_good`=1.
- **`rx_er`=1 for one cycle** mid-frame on a valid-CRC 64-byte frame → `m_phy_err`=1, `m_crc_err`=0. A 3-byte frame after SFD → `m_runt_drop` pulse, no `m_valid`.
- **Reset mid-frame:** `rst_n`=0 for one cycle at payload byte 20 → no `m_eof` and all outputs 0 next cycle. The following good 64-byte frame gives `m_good`=1 with a 1-cycle IPG.

Source files
------------

// File: rtl/eth_rx_framer_if.sv
// eth_rx_framer_if: byte-stream bundle around the rx framer.
//   rx_data/rx_dv/rx_er : GMII-style PHY byte stream into the framer.
//   m_*                 : payload stream out of the framer. The status bits
//                         are only meaningful on the m_eof beat.
// Modports: master = framer side (consumes rx_*, drives m_*),
//           slave  = environment side (drives rx_*, consumes m_*).
interface eth_rx_framer_if;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic       rx_er;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_sof;
  logic       m_eof;
  logic       m_crc_err;
  logic       m_len_err;
  logic       m_phy_err;
  logic       m_good;
  logic       m_runt_drop;

  modport master (
    input  rx_data, rx_dv, rx_er,
    output m_data, m_valid, m_sof, m_eof, m_crc_err, m_len_err,
           m_phy_err, m_good, m_runt_drop
  );

  modport slave (
    output rx_data, rx_dv, rx_er,
    input  m_data, m_valid, m_sof, m_eof, m_crc_err, m_len_err,
           m_phy_err, m_good, m_runt_drop
  );
endinterface

// File: rtl/eth_rx_framer.sv
// eth_rx_framer: receive-side framing stage.
// Strips preamble/SFD, checks CRC-32 residue, frame length and PHY error,
// and removes the 4-byte FCS with a 5-byte delay line so only payload bytes
// (dest addr .. data) reach the consumer. No backpressure.
// Ports:
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : eth_rx_framer_if.master (rx_* in, m_* out, all outputs registered)
module eth_rx_framer #(
  parameter int unsigned MIN_PREAMBLE = 1,
  parameter int unsigned MIN_LEN      = 64,
  parameter int unsigned MAX_LEN      = 1518
) (
  input  logic             clk,
  input  logic             rst_n,
  eth_rx_framer_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [11:0] MIN_LEN_C   = 12'(MIN_LEN);
  localparam logic [11:0] MAX_LEN_C   = 12'(MAX_LEN);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'b0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      pcnt_q, pcnt_d;
  logic [11:0]     bcnt_q, bcnt_d;
  logic [31:0]     crc_q, crc_d;
  logic [4:0][7:0] dly_q, dly_d;   // [0] newest, [4] oldest
  logic            phy_err_q, phy_err_d;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       sof_q, sof_d;
  logic       eof_q, eof_d;
  logic       crc_err_q, crc_err_d;
  logic       len_err_q, len_err_d;
  logic       phy_q, phy_d;
  logic       good_q, good_d;
  logic       runt_q, runt_d;

  logic crc_bad, len_bad;
  assign crc_bad = (crc_q != CRC_RESIDUE);
  assign len_bad = (bcnt_q < MIN_LEN_C) || (bcnt_q > MAX_LEN_C);

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    bcnt_d    = bcnt_q;
    crc_d     = crc_q;
    dly_d     = dly_q;
    phy_err_d = phy_err_q;
    data_d    = '0;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    crc_err_d = 1'b0;
    len_err_d = 1'b0;
    phy_d     = 1'b0;
    good_d    = 1'b0;
    runt_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_dv) begin
          if (bus.rx_data == 8'h55) begin
            state_d = S_PREAMBLE;
            pcnt_d  = 3'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end

      S_PREAMBLE: begin
        if (!bus.rx_dv) begin
          state_d = S_IDLE;
        end else if (bus.rx_data == 8'h55) begin
          if (pcnt_q != 3'd7) pcnt_d = pcnt_q + 3'd1;
        end else if ((bus.rx_data == 8'hD5) && (32'(pcnt_q) >= MIN_PREAMBLE)) begin
          state_d   = S_DATA;
          bcnt_d    = '0;
          crc_d     = '1;
          dly_d     = '0;
          phy_err_d = 1'b0;
        end else begin
          state_d = S_DROP;
        end
      end

      S_DATA: begin
        if (bus.rx_dv) begin
          if (bcnt_q != 12'hFFF) bcnt_d = bcnt_q + 12'd1;
          crc_d = crc_byte(crc_q, bus.rx_data);
          dly_d = {dly_q[3:0], bus.rx_data};
          if (bus.rx_er) phy_err_d = 1'b1;
          // Line is full once 5 bytes are held; the oldest is then payload.
          if (bcnt_q >= 12'd5) begin
            valid_d = 1'b1;
            data_d  = dly_q[4];
            sof_d   = (bcnt_q == 12'd5);
          end
        end else begin
          state_d = S_IDLE;
          // The 4 newest held bytes are the FCS; the oldest is the last payload byte.
          if (bcnt_q >= 12'd5) begin
            valid_d   = 1'b1;
            data_d    = dly_q[4];
            sof_d     = (bcnt_q == 12'd5);
            eof_d     = 1'b1;
            crc_err_d = crc_bad;
            len_err_d = len_bad;
            phy_d     = phy_err_q;
            good_d    = !(crc_bad || len_bad || phy_err_q);
          end else begin
            runt_d = 1'b1;
          end
        end
      end

      S_DROP: begin
        if (!bus.rx_dv) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pcnt_q    <= '0;
      bcnt_q    <= '0;
      crc_q     <= '0;
      dly_q     <= '0;
      phy_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      phy_q     <= 1'b0;
      good_q    <= 1'b0;
      runt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      bcnt_q    <= bcnt_d;
      crc_q     <= crc_d;
      dly_q     <= dly_d;
      phy_err_q <= phy_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      crc_err_q <= crc_err_d;
      len_err_q <= len_err_d;
      phy_q     <= phy_d;
      good_q    <= good_d;
      runt_q    <= runt_d;
    end
  end

  assign bus.m_data      = data_q;
  assign bus.m_valid     = valid_q;
  assign bus.m_sof       = sof_q;
  assign bus.m_eof       = eof_q;
  assign bus.m_crc_err   = crc_err_q;
  assign bus.m_len_err   = len_err_q;
  assign bus.m_phy_err   = phy_q;
  assign bus.m_good      = good_q;
  assign bus.m_runt_drop = runt_q;

endmodule
